// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store unit in front of a byte-lane data RAM
//               with a 2-cycle registered read. Builds byte selects and
//               lane-replicated store data, extends load results and flags
//               misaligned accesses (ADEL/ADES) without touching the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_uns,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] badvaddr
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_RESP = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_we;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata_rep;

    logic                w_ready;
    logic                w_accept;
    logic                w_misalign;
    logic [31:0]         w_wdata_rep;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
    logic [3:0]          w_store_sel;

    logic                w_ce;
    logic                w_we;
    logic [3:0]          w_sel;
    logic                w_rsp_valid;
    logic [31:0]         w_rsp_rdata;
    logic                w_adel;
    logic                w_ades;
    logic [ADDR_W-1:0]   w_badvaddr;

    // Request handshake: ready only in IDLE and never while reset is held
    assign w_ready  = rst & (r_state == S_IDLE);
    assign w_accept = req_valid & w_ready & ~flush;

    // Halves need bit 0 clear; words (and reserved size) need both low bits clear
    assign w_misalign = ((req_size == c_SIZE_HALF) & req_addr[0]) |
                        (req_size[1] & (req_addr[1:0] != 2'b00));

    // Store data replicated across lanes so the RAM picks it up by byte select
    always_comb begin
        w_wdata_rep = req_wdata;
        case (req_size)
            c_SIZE_BYTE: w_wdata_rep = {4{req_wdata[7:0]}};
            c_SIZE_HALF: w_wdata_rep = {2{req_wdata[15:0]}};
            default:     w_wdata_rep = req_wdata;
        endcase
    end

    // Store byte-lane enables from the latched size and low address bits
    always_comb begin
        w_store_sel = 4'b1111;
        case (r_size)
            c_SIZE_BYTE: w_store_sel = 4'b0001 << r_addr[1:0];
            c_SIZE_HALF: w_store_sel = r_addr[1] ? 4'b1100 : 4'b0011;
            default:     w_store_sel = 4'b1111;
        endcase
    end

    // Load lane extraction and sign/zero extension
    assign w_byte = ram_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        w_load = ram_rdata;
        case (r_size)
            c_SIZE_BYTE: w_load = {{24{w_byte[7] & ~r_uns}}, w_byte};
            c_SIZE_HALF: w_load = {{16{w_half[15] & ~r_uns}}, w_half};
            default:     w_load = ram_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture on accept
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_addr      <= '0;
            r_wdata_rep <= 32'd0;
        end else if (w_accept) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_uns       <= req_uns;
            r_addr      <= req_addr;
            r_wdata_rep <= w_wdata_rep;
        end
    end

    // Next-state and per-state RAM / response controls
    always_comb begin
        w_next      = r_state;
        w_ce        = 1'b0;
        w_we        = 1'b0;
        w_sel       = 4'b0000;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = 32'd0;
        w_adel      = 1'b0;
        w_ades      = 1'b0;
        w_badvaddr  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign)  w_next = S_ERR;
                    else if (req_we) w_next = S_WR;
                    else             w_next = S_RD1;
                end
            end
            S_WR: begin
                // The write commits at the end of this cycle even under flush
                w_ce        = 1'b1;
                w_we        = 1'b1;
                w_sel       = w_store_sel;
                w_rsp_valid = 1'b1;
                w_next      = S_IDLE;
            end
            S_RD1: begin
                w_ce   = 1'b1;
                w_sel  = 4'b1111;
                w_next = S_RD2;
            end
            S_RD2: begin
                w_ce   = 1'b1;
                w_sel  = 4'b1111;
                w_next = S_RESP;
            end
            S_RESP: begin
                // ce low keeps the RAM's output register holding the read word
                w_rsp_valid = 1'b1;
                w_rsp_rdata = w_load;
                w_next      = S_IDLE;
            end
            S_ERR: begin
                w_rsp_valid = 1'b1;
                w_adel      = ~r_we;
                w_ades      = r_we;
                w_badvaddr  = r_addr;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (flush) begin
            w_next      = S_IDLE;
            w_rsp_valid = 1'b0;
            w_rsp_rdata = 32'd0;
            w_adel      = 1'b0;
            w_ades      = 1'b0;
        end
    end

    // Every output is forced low while reset is held
    assign req_ready = w_ready;
    assign ram_ce    = rst & w_ce;
    assign ram_we    = rst & w_we;
    assign ram_sel   = rst ? w_sel : 4'b0000;
    assign ram_addr  = rst ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign ram_wdata = rst ? r_wdata_rep : 32'd0;
    assign rsp_valid = rst & w_rsp_valid;
    assign rsp_rdata = rst ? w_rsp_rdata : 32'd0;
    assign adel      = rst & w_adel;
    assign ades      = rst & w_ades;
    assign badvaddr  = rst ? w_badvaddr : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit with a behavioural
//               2-cycle registered byte-lane RAM and a byte-array shadow model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_uns = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'd0;
    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_sel;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              adel;
    logic              ades;
    logic [ADDR_W-1:0] badvaddr;

    int n_vec = 0;
    int n_err = 0;

    // Bench RAM: 64 words, byte-lane writes, 2-stage registered read
    logic [31:0] ram [0:63];
    logic [31:0] rd_stage = 32'd0;
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'd0;

    // Reference byte memory
    logic [7:0]  sh [0:255];

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_sel(ram_sel), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .adel(adel), .ades(ades), .badvaddr(badvaddr)
    );

    always #5 clk = ~clk;

    // RAM behaviour (preload port used only before traffic starts)
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_idx] <= pl_data;
        end else if (ram_ce && ram_we) begin
            for (int i = 0; i < 4; i++)
                if (ram_sel[i]) ram[ram_addr[7:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
        end else if (ram_ce) begin
            rd_stage  <= ram[ram_addr[7:2]];
            ram_rdata <= rd_stage;
        end
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misaligned(input logic [1:0] size, input logic [31:0] addr);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] s;
        int off;
        off = addr % 4;
        s = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nbytes(size)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        int nb;
        nb = nbytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
        logic [31:0] v;
        int nb;
        nb = nbytes(size);
        v = 32'd0;
        for (int k = 0; k < nb; k++) v = v | (32'(sh[addr[7:0] + 8'(k)]) << (8 * k));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] sh_word(input int idx);
        return {sh[4*idx+3], sh[4*idx+2], sh[4*idx+1], sh[4*idx]};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({req_ready, ram_ce, ram_we, ram_sel, rsp_valid, adel, ades}), 32'd0);
        check({tag, "_ram_addr"}, ram_addr, 32'd0);
        check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_badvaddr"}, badvaddr, 32'd0);
    endtask

    // One request from presentation to return to IDLE, checked cycle by cycle
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
        req_addr = addr; req_wdata = wdata;
        #1 check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        if (misaligned(size, addr)) begin
            check("err_valid", rsp_valid, 1);
            check("err_adel", adel, !we);
            check("err_ades", ades, we);
            check("err_badvaddr", badvaddr, addr);
            check("err_ram_ce", ram_ce, 0);
            check("err_rdata", rsp_rdata, 0);
        end else if (we) begin
            check("wr_ce_we", {ram_ce, ram_we}, 2'b11);
            check("wr_sel", ram_sel, exp_sel(size, addr));
            check("wr_wdata", ram_wdata, exp_wdata(size, wdata));
            check("wr_addr", ram_addr, addr & ~32'd3);
            check("wr_valid", rsp_valid, 1);
            check("wr_rdata", rsp_rdata, 0);
            check("wr_exc", {adel, ades}, 0);
            for (int k = 0; k < nbytes(size); k++) sh[addr[7:0] + 8'(k)] = wdata[8*k +: 8];
        end else begin
            for (int c = 0; c < 2; c++) begin
                check("rd_ce_we", {ram_ce, ram_we}, 2'b10);
                check("rd_sel", ram_sel, 4'hF);
                check("rd_addr", ram_addr, addr & ~32'd3);
                check("rd_valid_early", rsp_valid, 0);
                @(negedge clk); #1;
            end
            check("resp_ce", ram_ce, 0);
            check("resp_valid", rsp_valid, 1);
            check("resp_rdata", rsp_rdata, exp_load(size, uns, addr));
            check("resp_exc", {adel, ades}, 0);
        end
        @(negedge clk); #1;
        check("back_idle_ready", req_ready, 1);
        check("back_idle_valid", rsp_valid, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic        w;

        // Random initial memory, mirrored into the RAM through the preload port
        for (int i = 0; i < 256; i++) sh[i] = 8'($urandom);
        sh[8'h10] = 8'h01; sh[8'h11] = 8'h7F; sh[8'h12] = 8'hF0; sh[8'h13] = 8'h80;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_idx = 6'(i); pl_data = sh_word(i);
        end
        @(negedge clk);
        pl_en = 1'b0;
        #1 check_all_zero("reset_hold");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check("reset_release_ready", req_ready, 1);

        // Loads from the 0x80F07F01 word
        issue(0, 2'd0, 0, 32'h13, 32'h0);
        issue(0, 2'd0, 1, 32'h13, 32'h0);
        issue(0, 2'd1, 0, 32'h12, 32'h0);
        issue(0, 2'd2, 0, 32'h10, 32'h0);

        // Stores and the exception paths
        issue(1, 2'd0, 0, 32'h13, 32'h000000AB);
        issue(0, 2'd2, 0, 32'h10, 32'h0);
        issue(0, 2'd2, 0, 32'h22, 32'h0);
        issue(1, 2'd1, 0, 32'h21, 32'hDEAD);
        @(negedge clk); #1;
        check("ades_ram_untouched", ram[8], sh_word(8));

        // Flush in RD2: no response, back in IDLE
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        #1 check("flush_rd2_valid", rsp_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        #1 check("flush_rd2_idle", req_ready, 1);
        check("flush_rd2_novalid", rsp_valid, 0);

        // Flush in WR: response suppressed, write still commits
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1;
        #1 check("flush_wr_we", {ram_ce, ram_we}, 2'b11);
        check("flush_wr_valid", rsp_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        #1 check("flush_wr_commit", ram[16], 32'h12345678);
        for (int k = 0; k < 4; k++) sh[8'h40 + 8'(k)] = req_wdata[8*k +: 8];

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1 check("flush_idle_no_access", ram_ce, 0);
        check("flush_idle_ready", req_ready, 1);

        // Reset in RD1 drops the request
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b0;
        @(negedge clk); #1;
        check_all_zero("reset_rd1");
        rst = 1'b1;
        @(negedge clk); #1;
        check("reset_after_ready", req_ready, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("reset_dropped_rsp", rsp_valid, 0);
        end

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
            issue(w, sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
